// File: rtl/falling_edge_dff_pkg.sv
// rtl/falling_edge_dff_pkg.sv - shared constants for the falling-edge flip-flop
package falling_edge_dff_pkg;
    localparam logic Q_RESET  = 1'b0;
    localparam logic Q_PRESET = 1'b1;
endpackage

// File: rtl/falling_edge_dff_if.sv
// rtl/falling_edge_dff_if.sv - data/output bundle of the falling-edge flip-flop
interface falling_edge_dff_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Qb;

    modport master (output D, input Q, input Qb);
    modport slave  (input D, output Q, output Qb);
endinterface

// File: rtl/falling_edge_dff_dlatch_sr.sv
// rtl/falling_edge_dff_dlatch_sr.sv - level-sensitive D latch, active-low set/clear
module falling_edge_dff_dlatch_sr
    import falling_edge_dff_pkg::*;
(
    input  logic en,
    input  logic d,
    input  logic set_n,
    input  logic clr_n,
    output logic q
);
    // Clear wins over set so S=R=0 resolves to a defined state.
    always_latch begin
        if (!clr_n)
            q <= Q_RESET;
        else if (!set_n)
            q <= Q_PRESET;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/falling_edge_dff.sv
// rtl/falling_edge_dff.sv - master-slave D flip-flop capturing on the falling clock edge
module falling_edge_dff
    import falling_edge_dff_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic            clk,
    input  logic            R,
    input  logic            S,
    falling_edge_dff_if.slave bus
);
    logic [WIDTH-1:0] master_q;
    logic [WIDTH-1:0] slave_q;

    // Master follows D while clk is high; slave copies master while clk is low,
    // so the value present at the 1->0 transition is what appears on Q.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        falling_edge_dff_dlatch_sr u_master (
            .en    (clk),
            .d     (bus.D[i]),
            .set_n (S),
            .clr_n (R),
            .q     (master_q[i])
        );

        falling_edge_dff_dlatch_sr u_slave (
            .en    (~clk),
            .d     (master_q[i]),
            .set_n (S),
            .clr_n (R),
            .q     (slave_q[i])
        );
    end

    assign bus.Q  = slave_q;
    assign bus.Qb = ~slave_q;
endmodule

// File: tb/tb_falling_edge_dff.sv
// tb/tb_falling_edge_dff.sv - directed and randomized bench for falling_edge_dff
module tb_falling_edge_dff;
    localparam int W = 4;
    localparam logic [W-1:0] ONES = '1;

    logic clk;
    logic R;
    logic S;
    logic [W-1:0] exp_q;
    int compared;
    int mism;

    falling_edge_dff_if #(.WIDTH(W)) bus ();

    falling_edge_dff #(.WIDTH(W)) dut (
        .clk (clk),
        .R   (R),
        .S   (S),
        .bus (bus)
    );

    task automatic check(input string tag);
        compared++;
        assert (bus.Q === exp_q) else begin
            mism++;
            $error("FAIL %s: Q observed %h expected %h", tag, bus.Q, exp_q);
        end
        compared++;
        assert (bus.Qb === ~exp_q) else begin
            mism++;
            $error("FAIL %s_qb: Qb observed %h expected %h", tag, bus.Qb, ~exp_q);
        end
    endtask

    // Reference rules: clear dominates, then preset, otherwise hold.
    task automatic apply_sr(input logic s_v, input logic r_v);
        S = s_v;
        R = r_v;
        if (!r_v)      exp_q = '0;
        else if (!s_v) exp_q = ONES;
        #1;
    endtask

    task automatic rise(input string tag);
        clk = 1'b1;
        #1;
        check(tag);
        #4;
    endtask

    task automatic fall(input string tag);
        clk = 1'b0;
        if (S && R) exp_q = bus.D === 'x ? 'x : bus.D;
        #1;
        check(tag);
        #4;
    endtask

    initial begin
        compared = 0;
        mism     = 0;
        clk      = 1'b0;
        bus.D    = '0;
        S        = 1'b1;
        R        = 1'b0;
        exp_q    = '0;
        #1;
        check("reset");
        apply_sr(1'b1, 1'b1);
        check("reset_release_hold");

        // Preset pulse of 4 units, then hold until a falling edge.
        apply_sr(1'b0, 1'b1);
        check("preset_immediate");
        #3;
        apply_sr(1'b1, 1'b1);
        check("preset_release_hold");
        rise("preset_hold_rise");
        fall("fall_d0");

        bus.D = ONES;
        rise("rise_no_effect");
        fall("fall_d1");

        // D changes mid high phase, then toggles back during the low phase.
        clk = 1'b1;
        #2;
        bus.D = 4'h0;
        #1;
        check("mid_high_hold");
        #2;
        fall("fall_mid_high_d");
        bus.D = ONES;
        #1;
        check("low_phase_hold");
        rise("rise_hold");
        fall("fall_after_toggle");

        // Clear pulse with static clock while Q is all ones.
        apply_sr(1'b1, 1'b0);
        check("clear_immediate");
        apply_sr(1'b1, 1'b1);
        check("clear_release_hold");
        bus.D = ONES;
        rise("clear_hold_rise");
        fall("clear_then_sample");

        // Both asserted: clear wins; release clear first exposes preset.
        apply_sr(1'b0, 1'b0);
        check("both_asserted");
        apply_sr(1'b0, 1'b1);
        check("release_r_first");
        apply_sr(1'b1, 1'b1);
        check("release_s_hold");

        // Period-20 clock, D = 0 (45), ones (40), 0 (40); edges at multiples of 10.
        for (int k = 0; k < 25; k++) begin
            int t;
            logic nclk;
            t = k * 5;
            nclk = ((t / 10) % 2 == 0);
            bus.D = (t < 45) ? '0 : (t < 85) ? ONES : '0;
            if (clk && !nclk && S && R) exp_q = bus.D;
            clk = nclk;
            #1;
            check("d_sequence");
            #4;
        end
        if (clk) begin
            clk = 1'b0;
            exp_q = bus.D;
            #5;
        end

        // Randomized operations against the reference rules.
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0: begin
                    bus.D = W'($urandom);
                    rise("rnd_rise");
                    fall("rnd_fall");
                end
                1: begin
                    apply_sr(1'b0, 1'b1);
                    check("rnd_preset");
                    apply_sr(1'b1, 1'b1);
                    check("rnd_preset_rel");
                end
                2: begin
                    apply_sr(1'b1, 1'b0);
                    check("rnd_clear");
                    apply_sr(1'b1, 1'b1);
                    check("rnd_clear_rel");
                end
                default: begin
                    bus.D = W'($urandom);
                    #1;
                    check("rnd_d_low_hold");
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
